// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master
//  Description : SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first, one
//                DATA_WIDTH-bit word per transfer. Optional bursts keep chip
//                select low between words until the host releases it.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1   system clock, all logic on rising edge
//    rst_n        in   1   asynchronous active-low reset
//    i_start      in   1   transfer request, honoured in IDLE or BURST only
//    i_tx_data    in   DW  word to send, latched on an accepted start
//    i_keep_cs    in   1   latched with start; 1 = remain in BURST afterwards
//    i_cs_release in   1   in BURST without start: close the burst
//    o_rx_data    out  DW  received word, valid with o_done, held until next
//    o_busy       out  1   high in SETUP / XFER / HOLD
//    o_done       out  1   one-cycle pulse per completed word
//    o_spi_clk    out  1   SPI clock, idles low
//    o_mosi       out  1   SPI data out
//    i_miso       in   1   SPI data in
//    o_cs         out  1   chip select, active low
// ============================================================================
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_keep_cs,
  input  logic                  i_cs_release,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_spi_clk,
  output logic                  o_mosi,
  input  logic                  i_miso,
  output logic                  o_cs
);

  // One shared down-timer serves SETUP, XFER half-periods and HOLD, so it is
  // sized for the longest of the three intervals.
  localparam int c_CNT_MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int c_CNT_MAX   = (c_CNT_MAX_A > CS_HOLD) ? c_CNT_MAX_A : CS_HOLD;
  localparam int c_CNT_W     = $clog2(c_CNT_MAX + 1);
  localparam int c_BIT_W     = $clog2(DATA_WIDTH + 1);

  localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(CS_SETUP - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST  = c_CNT_W'(CLK_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(CS_HOLD - 1);
  localparam logic [c_BIT_W-1:0] c_BITS       = c_BIT_W'(DATA_WIDTH);

  if ((CLK_DIV < 2) || (CS_SETUP < 1) || (CS_HOLD < 1) || (DATA_WIDTH < 2)) begin : g_param_check
    $error("spi_master: CLK_DIV must be >= 2, CS_SETUP/CS_HOLD >= 1, DATA_WIDTH >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_HOLD  = 3'd3,
    S_BURST = 3'd4
  } state_t;

  state_t                r_state,     w_state;
  logic [c_CNT_W-1:0]    r_cnt,       w_cnt;
  logic [c_BIT_W-1:0]    r_bit_cnt,   w_bit_cnt;
  logic [DATA_WIDTH-1:0] r_tx_sh,     w_tx_sh;
  logic [DATA_WIDTH-1:0] r_rx_sh,     w_rx_sh;
  logic [DATA_WIDTH-1:0] r_rx_data,   w_rx_data;
  logic                  r_keep,      w_keep;
  logic                  r_hold_done, w_hold_done;
  logic                  r_busy,      w_busy;
  logic                  r_done,      w_done;
  logic                  r_sclk,      w_sclk;
  logic                  r_mosi,      w_mosi;
  logic                  r_cs,        w_cs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_cnt   <= '0;
      r_tx_sh     <= '0;
      r_rx_sh     <= '0;
      r_rx_data   <= '0;
      r_keep      <= 1'b0;
      r_hold_done <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_cs        <= 1'b1;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_bit_cnt   <= w_bit_cnt;
      r_tx_sh     <= w_tx_sh;
      r_rx_sh     <= w_rx_sh;
      r_rx_data   <= w_rx_data;
      r_keep      <= w_keep;
      r_hold_done <= w_hold_done;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_sclk      <= w_sclk;
      r_mosi      <= w_mosi;
      r_cs        <= w_cs;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_bit_cnt   = r_bit_cnt;
    w_tx_sh     = r_tx_sh;
    w_rx_sh     = r_rx_sh;
    w_rx_data   = r_rx_data;
    w_keep      = r_keep;
    w_hold_done = r_hold_done;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_sclk      = r_sclk;
    w_mosi      = r_mosi;
    w_cs        = r_cs;

    case (r_state)
      S_IDLE: begin
        w_cs = 1'b1;
        if (i_start) begin
          w_tx_sh   = i_tx_data;
          w_keep    = i_keep_cs;
          w_mosi    = i_tx_data[DATA_WIDTH-1];
          w_cs      = 1'b0;
          w_busy    = 1'b1;
          w_cnt     = '0;
          w_bit_cnt = '0;
          w_state   = S_SETUP;
        end
      end

      S_SETUP: begin
        if (r_cnt == c_SETUP_LAST) begin
          w_cnt   = '0;
          w_state = S_XFER;
        end else begin
          w_cnt = r_cnt + c_CNT_W'(1);
        end
      end

      S_XFER: begin
        if (r_cnt == c_HALF_LAST) begin
          w_cnt  = '0;
          w_sclk = ~r_sclk;
          if (!r_sclk) begin
            // Rising edge: capture the slave's bit.
            w_rx_sh   = {r_rx_sh[DATA_WIDTH-2:0], i_miso};
            w_bit_cnt = r_bit_cnt + c_BIT_W'(1);
          end else begin
            // Falling edge: present the next bit for the following rise.
            w_tx_sh = {r_tx_sh[DATA_WIDTH-2:0], 1'b0};
            w_mosi  = r_tx_sh[DATA_WIDTH-2];
            if (r_bit_cnt == c_BITS) begin
              // Last falling edge: all bits already captured.
              w_rx_data = r_rx_sh;
              w_bit_cnt = '0;
              if (r_keep) begin
                w_done  = 1'b1;
                w_busy  = 1'b0;
                w_state = S_BURST;
              end else begin
                w_hold_done = 1'b1;
                w_state     = S_HOLD;
              end
            end
          end
        end else begin
          w_cnt = r_cnt + c_CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (r_cnt == c_HOLD_LAST) begin
          w_cnt   = '0;
          w_cs    = 1'b1;
          w_busy  = 1'b0;
          // A burst closed by cs_release already reported its last word.
          w_done  = r_hold_done;
          w_state = S_IDLE;
        end else begin
          w_cnt = r_cnt + c_CNT_W'(1);
        end
      end

      S_BURST: begin
        w_cs   = 1'b0;
        w_sclk = 1'b0;
        if (i_start) begin
          // Start takes priority over a simultaneous cs_release.
          w_tx_sh   = i_tx_data;
          w_keep    = i_keep_cs;
          w_mosi    = i_tx_data[DATA_WIDTH-1];
          w_busy    = 1'b1;
          w_cnt     = '0;
          w_bit_cnt = '0;
          w_state   = S_XFER;
        end else if (i_cs_release) begin
          w_busy      = 1'b1;
          w_cnt       = '0;
          w_hold_done = 1'b0;
          w_state     = S_HOLD;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign o_rx_data = r_rx_data;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_spi_clk = r_sclk;
  assign o_mosi    = r_mosi;
  assign o_cs      = r_cs;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master
//  Description : Directed self-checking bench for spi_master with a
//                scoreboard of expected received words and a mode-0 slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

  localparam int DW       = 8;
  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_LOW_CYCLES = CS_SETUP + 2 * DW * CLK_DIV + CS_HOLD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [DW-1:0] i_tx_data = '0;
  logic          i_keep_cs = 1'b0;
  logic          i_cs_release = 1'b0;
  logic [DW-1:0] o_rx_data;
  logic          o_busy;
  logic          o_done;
  logic          o_spi_clk;
  logic          o_mosi;
  logic          w_miso;
  logic          o_cs;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];

  // Slave model: loads its byte when cs falls, shifts after each falling spiClk.
  logic          use_slave = 1'b0;
  logic [DW-1:0] s_byte = '0;
  logic [DW-1:0] s_sh = '0;
  logic          s_prev_cs = 1'b1;
  logic          s_prev_sclk = 1'b0;

  // Monitor state
  int            m_rises = 0;
  int            m_dones = 0;
  int            m_cs_rises = 0;
  int            m_cs_low = 0;
  int            m_last_cs_low = 0;
  logic [DW-1:0] m_mosi_cap = '0;
  logic          m_prev_sclk = 1'b0;
  logic          m_prev_cs = 1'b1;
  logic          m_prev_done = 1'b0;

  always #5 clk = ~clk;

  assign w_miso = use_slave ? s_sh[DW-1] : o_mosi;

  spi_master #(
    .DATA_WIDTH(DW),
    .CLK_DIV   (CLK_DIV),
    .CS_SETUP  (CS_SETUP),
    .CS_HOLD   (CS_HOLD)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_tx_data   (i_tx_data),
    .i_keep_cs   (i_keep_cs),
    .i_cs_release(i_cs_release),
    .o_rx_data   (o_rx_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_spi_clk   (o_spi_clk),
    .o_mosi      (o_mosi),
    .i_miso      (w_miso),
    .o_cs        (o_cs)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (s_prev_cs && !o_cs)
      s_sh <= s_byte;
    else if (s_prev_sclk && !o_spi_clk)
      s_sh <= {s_sh[DW-2:0], 1'b0};
    s_prev_cs   <= o_cs;
    s_prev_sclk <= o_spi_clk;
  end

  always @(negedge clk) begin
    logic [DW-1:0] exp_rx;
    if (o_spi_clk && !m_prev_sclk) begin
      m_rises++;
      m_mosi_cap = {m_mosi_cap[DW-2:0], o_mosi};
    end
    if (!o_cs) begin
      m_cs_low++;
    end else if (!m_prev_cs) begin
      m_last_cs_low = m_cs_low;
      m_cs_low = 0;
      m_cs_rises++;
    end
    if (o_done) begin
      m_dones++;
      check("done_one_cycle", {31'd0, m_prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        check("done_unexpected", {31'd0, o_done}, 32'd0);
      end else begin
        exp_rx = exp_q.pop_front();
        check("rx_data", {24'd0, o_rx_data}, {24'd0, exp_rx});
      end
    end
    m_prev_sclk = o_spi_clk;
    m_prev_cs   = o_cs;
    m_prev_done = o_done;
  end

  // Called on a negedge; the DUT accepts the request at the following posedge.
  task automatic pulse_start(input logic [DW-1:0] tx, input logic keep);
    i_start   = 1'b1;
    i_tx_data = tx;
    i_keep_cs = keep;
    @(negedge clk);
    i_start   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!o_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_done) check({tag, "_timeout"}, {31'd0, o_done}, 32'd1);
  endtask

  initial begin
    int r0, d0, c0, k, n;
    logic prev;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs",      {31'd0, o_cs},      32'd1);
    check("rst_spi_clk", {31'd0, o_spi_clk}, 32'd0);
    check("rst_mosi",    {31'd0, o_mosi},    32'd0);
    check("rst_busy",    {31'd0, o_busy},    32'd0);
    check("rst_done",    {31'd0, o_done},    32'd0);
    check("rst_rx_data", {24'd0, o_rx_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: loopback 0xA5
    r0 = m_rises; d0 = m_dones;
    exp_q.push_back(8'hA5);
    pulse_start(8'hA5, 1'b0);
    check("t1_busy_after_start", {31'd0, o_busy}, 32'd1);
    check("t1_cs_after_start",   {31'd0, o_cs},   32'd0);
    wait_done("t1_done");
    check("t1_cs_at_done",   {31'd0, o_cs},   32'd1);
    check("t1_busy_at_done", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    check("t1_cs_low_len", m_last_cs_low, CS_LOW_CYCLES);
    check("t1_rises",      m_rises - r0,  8);
    check("t1_done_count", m_dones - d0,  1);
    check("t1_done_width", {31'd0, o_done}, 32'd0);

    // 2: slave returns 0x3C while master sends 0xC3
    use_slave = 1'b1;
    s_byte    = 8'h3C;
    exp_q.push_back(8'h3C);
    pulse_start(8'hC3, 1'b0);
    wait_done("t2_done");
    @(negedge clk);
    check("t2_mosi_bits", {24'd0, m_mosi_cap}, 32'h0000_00C3);
    use_slave = 1'b0;
    repeat (3) @(negedge clk);

    // 3: burst 0x12, 0x34, then cs_release
    r0 = m_rises; d0 = m_dones; c0 = m_cs_rises;
    exp_q.push_back(8'h12);
    pulse_start(8'h12, 1'b1);
    wait_done("t3_done1");
    check("t3_cs_low_burst1", {31'd0, o_cs},   32'd0);
    check("t3_busy_burst1",   {31'd0, o_busy}, 32'd0);
    exp_q.push_back(8'h34);
    pulse_start(8'h34, 1'b1);
    wait_done("t3_done2");
    check("t3_cs_low_burst2", {31'd0, o_cs}, 32'd0);
    i_cs_release = 1'b1;
    @(negedge clk);
    i_cs_release = 1'b0;
    check("t3_hold_busy",  {31'd0, o_busy}, 32'd1);
    check("t3_hold_cs_0",  {31'd0, o_cs},   32'd0);
    @(negedge clk);
    check("t3_hold_cs_1",  {31'd0, o_cs},   32'd0);
    @(negedge clk);
    check("t3_cs_rise",    {31'd0, o_cs},   32'd1);
    check("t3_idle_busy",  {31'd0, o_busy}, 32'd0);
    repeat (20) @(negedge clk);
    check("t3_done_count", m_dones - d0,    2);
    check("t3_cs_rises",   m_cs_rises - c0, 1);
    check("t3_rises",      m_rises - r0,    16);

    // 4: second start mid-transfer is ignored
    r0 = m_rises; d0 = m_dones;
    exp_q.push_back(8'h5A);
    pulse_start(8'h5A, 1'b0);
    repeat (9) @(negedge clk);
    pulse_start(8'hFF, 1'b0);
    check("t4_busy_mid", {31'd0, o_busy}, 32'd1);
    wait_done("t4_done");
    repeat (80) @(negedge clk);
    check("t4_done_count", m_dones - d0, 1);
    check("t4_rises",      m_rises - r0, 8);
    check("t4_cs_idle",    {31'd0, o_cs}, 32'd1);

    // 5: reset after the 3rd rise of 0xFF
    d0 = m_dones;
    pulse_start(8'hFF, 1'b0);
    k = 0; n = 0; prev = o_spi_clk;
    while (k < 3 && n < 100) begin
      @(negedge clk);
      if (o_spi_clk && !prev) k++;
      prev = o_spi_clk;
      n++;
    end
    check("t5_third_rise", k, 3);
    rst_n = 1'b0;
    #1;
    check("t5_rst_cs",      {31'd0, o_cs},      32'd1);
    check("t5_rst_spi_clk", {31'd0, o_spi_clk}, 32'd0);
    check("t5_rst_mosi",    {31'd0, o_mosi},    32'd0);
    check("t5_rst_rx_data", {24'd0, o_rx_data}, 32'd0);
    check("t5_rst_busy",    {31'd0, o_busy},    32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_no_done", m_dones - d0, 0);
    exp_q.push_back(8'h81);
    pulse_start(8'h81, 1'b0);
    wait_done("t5_done");
    @(negedge clk);
    check("t5_done_count", m_dones - d0, 1);
    check("t5_cs_low_len", m_last_cs_low, CS_LOW_CYCLES);

    // 6: start and cs_release together in BURST
    exp_q.push_back(8'h11);
    pulse_start(8'h11, 1'b1);
    wait_done("t6_done1");
    exp_q.push_back(8'h22);
    i_start      = 1'b1;
    i_cs_release = 1'b1;
    i_tx_data    = 8'h22;
    i_keep_cs    = 1'b1;
    @(negedge clk);
    i_start      = 1'b0;
    i_cs_release = 1'b0;
    check("t6_busy_after", {31'd0, o_busy}, 32'd1);
    check("t6_cs_after",   {31'd0, o_cs},   32'd0);
    wait_done("t6_done2");
    check("t6_cs_at_done", {31'd0, o_cs},   32'd0);
    repeat (5) @(negedge clk);
    check("t6_burst_cs",   {31'd0, o_cs},   32'd0);
    check("t6_burst_busy", {31'd0, o_busy}, 32'd0);
    i_cs_release = 1'b1;
    @(negedge clk);
    i_cs_release = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_cs_released", {31'd0, o_cs}, 32'd1);

    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
